// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter and its RAM.
package mem_arb_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with a registered read port; writes leave rdata untouched.
module sp_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of sp_ram: fills mem[i]=i after reset, then
// serves A/B round-robin. Define ARB_FIXED_PRIO_EN to make A win every tie.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          init_done
);

  state_t        state;
  logic [AW-1:0] init_cnt;
  logic [DW-1:0] init_data;
  logic          run;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          rd_valid;
  logic          rd_owner;
  logic [DW-1:0] a_hold;
  logic [DW-1:0] b_hold;

  assign run       = (state == RUN);
  assign init_done = run;
  assign init_data = DW'(init_cnt);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == {AW{1'b1}}) begin
        state <= RUN;
      end
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    a_gnt = run & a_req;
    b_gnt = run & b_req & ~a_req;
  end
`else
  // last names the most recent winner; the other side wins a tie.
  logic last;

  always_comb begin
    a_gnt = run & a_req & (~b_req | (last == REQ_B));
    b_gnt = run & b_req & (~a_req | (last == REQ_A));
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      last <= REQ_B;
    end else if (a_gnt) begin
      last <= REQ_A;
    end else if (b_gnt) begin
      last <= REQ_B;
    end
  end
`endif

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = init_cnt;
    ram_wdata = init_data;
    if (state == INIT) begin
      ram_en = 1'b1;
      ram_we = 1'b1;
    end else if (a_gnt) begin
      ram_en    = 1'b1;
      ram_we    = a_we;
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
    end else if (b_gnt) begin
      ram_en    = 1'b1;
      ram_we    = b_we;
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
    end
  end

  sp_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clock(clock),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_owner <= REQ_A;
    end else begin
      rd_valid <= (a_gnt & ~a_we) | (b_gnt & ~b_we);
      rd_owner <= b_gnt ? REQ_B : REQ_A;
    end
  end

  // The RAM output is shared, so each side latches its word to hold it between reads.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      a_hold <= '0;
      b_hold <= '0;
    end else begin
      if (a_rvalid) a_hold <= ram_rdata;
      if (b_rvalid) b_hold <= ram_rdata;
    end
  end

  assign a_rvalid = rd_valid & (rd_owner == REQ_A);
  assign b_rvalid = rd_valid & (rd_owner == REQ_B);
  assign a_rdata  = a_rvalid ? ram_rdata : a_hold;
  assign b_rdata  = b_rvalid ? ram_rdata : b_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// against a transaction-level model of the shared memory and arbitration rules.
module tb_mem_arbiter;

  logic       clock;
  logic       rst_n;
  logic       a_req, a_we, a_gnt, a_rvalid;
  logic [7:0] a_addr, a_wdata, a_rdata;
  logic       b_req, b_we, b_gnt, b_rvalid;
  logic [7:0] b_addr, b_wdata, b_rdata;
  logic       init_done;

  mem_arbiter dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .init_done(init_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit       idle;
    bit       we;
    bit [7:0] addr;
    bit [7:0] wdata;
  } req_t;

  req_t qa[$];
  req_t qb[$];

  bit [7:0] m_mem [256];
  bit       m_run;
  int       m_fill;
  bit       m_last_b;
  bit       exp_a_rvalid, exp_b_rvalid;
  bit [7:0] exp_a_rdata, exp_b_rdata;

  int check_count = 0;
  int fail_count  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'(i);
    m_run        = 1'b0;
    m_fill       = 0;
    m_last_b     = 1'b1;
    exp_a_rvalid = 1'b0;
    exp_b_rvalid = 1'b0;
    exp_a_rdata  = 8'h00;
    exp_b_rdata  = 8'h00;
  endtask

  function automatic req_t mk(input bit idle, input bit we, input bit [7:0] addr,
                              input bit [7:0] wdata);
    req_t r;
    r.idle  = idle;
    r.we    = we;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

  // Called just after a rising edge: drives queue heads, checks mid-cycle, advances the model.
  task automatic applyStimulus();
    bit ga, gb;
    if (qa.size() > 0 && !qa[0].idle) begin
      a_req = 1; a_we = qa[0].we; a_addr = qa[0].addr; a_wdata = qa[0].wdata;
    end else begin
      a_req = 0; a_we = 0; a_addr = 8'h00; a_wdata = 8'h00;
    end
    if (qb.size() > 0 && !qb[0].idle) begin
      b_req = 1; b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].wdata;
    end else begin
      b_req = 0; b_we = 0; b_addr = 8'h00; b_wdata = 8'h00;
    end

    ga = 0;
    gb = 0;
    if (m_run) begin
      if (a_req && b_req) begin
`ifdef ARB_FIXED_PRIO_EN
        ga = 1;
`else
        ga = m_last_b;
`endif
      end else begin
        ga = a_req;
      end
      gb = b_req && !ga;
    end

    @(negedge clock);
    checkOutput("init_done", init_done, m_run);
    checkOutput("a_gnt", a_gnt, ga);
    checkOutput("b_gnt", b_gnt, gb);
    checkOutput("a_rvalid", a_rvalid, exp_a_rvalid);
    checkOutput("b_rvalid", b_rvalid, exp_b_rvalid);
    checkOutput("a_rdata", a_rdata, exp_a_rdata);
    checkOutput("b_rdata", b_rdata, exp_b_rdata);

    @(posedge clock);
    exp_a_rvalid = 0;
    exp_b_rvalid = 0;
    if (!m_run) begin
      m_fill++;
      if (m_fill == 256) m_run = 1;
    end else begin
      if (ga) begin
        if (qa[0].we) m_mem[qa[0].addr] = qa[0].wdata;
        else begin exp_a_rvalid = 1; exp_a_rdata = m_mem[qa[0].addr]; end
        m_last_b = 0;
      end
      if (gb) begin
        if (qb[0].we) m_mem[qb[0].addr] = qb[0].wdata;
        else begin exp_b_rvalid = 1; exp_b_rdata = m_mem[qb[0].addr]; end
        m_last_b = 1;
      end
      if (qa.size() > 0 && (ga || qa[0].idle)) void'(qa.pop_front());
      if (qb.size() > 0 && (gb || qb[0].idle)) void'(qb.pop_front());
    end
    #1;
  endtask

  task automatic runUntilRun();
    for (int n = 0; n < 300 && !m_run; n++) applyStimulus();
  endtask

  task automatic drain();
    for (int n = 0; n < 2000 && (qa.size() > 0 || qb.size() > 0); n++) applyStimulus();
    checkOutput("queues_drained", qa.size() + qb.size(), 0);
    repeat (2) applyStimulus();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    modelReset();
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_init_done", init_done, 0);
    checkOutput("reset_a_gnt", a_gnt, 0);
    checkOutput("reset_b_rvalid", b_rvalid, 0);
    rst_n = 1;

    $display("[TB] fill check");
    qa.push_back(mk(0, 0, 8'h00, 8'h00));
    qa.push_back(mk(0, 0, 8'hFF, 8'h00));
    runUntilRun();
    checkOutput("fill_cycles", m_fill, 256);
    drain();

    $display("[TB] B streaming");
    for (int i = 0; i < 4; i++) qb.push_back(mk(0, 0, 8'(8'h10 + i), 8'h00));
    drain();

    $display("[TB] tie arbitration");
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mk(0, 0, 8'h20, 8'h00));
      qb.push_back(mk(0, 0, 8'h30, 8'h00));
    end
    drain();

    $display("[TB] write then read");
    qa.push_back(mk(0, 1, 8'h40, 8'h5A));
    qb.push_back(mk(1, 0, 8'h00, 8'h00));
    qb.push_back(mk(0, 0, 8'h40, 8'h00));
    drain();
    checkOutput("b_rdata_after_write", b_rdata, 8'h5A);

    $display("[TB] idle");
    repeat (10) applyStimulus();

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      if (qa.size() < 2)
        qa.push_back(mk($urandom_range(0, 3) == 0, $urandom_range(0, 1),
                        8'(8'h40 + $urandom_range(0, 7)), 8'($urandom)));
      if (qb.size() < 2)
        qb.push_back(mk($urandom_range(0, 3) == 0, $urandom_range(0, 1),
                        8'(8'h40 + $urandom_range(0, 7)), 8'($urandom)));
      applyStimulus();
    end
    drain();

    $display("[TB] reset mid-operation");
    qa.push_back(mk(0, 1, 8'h40, 8'h5A));
    qb.push_back(mk(1, 0, 8'h00, 8'h00));
    qb.push_back(mk(0, 0, 8'h40, 8'h00));
    repeat (2) applyStimulus();
    checkOutput("pre_reset_b_rvalid", b_rvalid, 1);
    checkOutput("pre_reset_b_rdata", b_rdata, 8'h5A);
    rst_n = 0;
    #1;
    checkOutput("midreset_b_rvalid", b_rvalid, 0);
    checkOutput("midreset_init_done", init_done, 0);
    checkOutput("midreset_b_rdata", b_rdata, 0);
    qa.delete();
    qb.delete();
    modelReset();
    a_req = 0; b_req = 0;
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1;
    qa.push_back(mk(0, 0, 8'h40, 8'h00));
    runUntilRun();
    checkOutput("refill_cycles", m_fill, 256);
    drain();
    checkOutput("a_rdata_after_refill", a_rdata, 8'h40);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port 256x8 synchronous memory between two requesters, A and B.
- After reset, a sequencer fills the memory with mem[i] = i. Only then are requesters served.
- Round-robin arbitration. At most one memory access per clock.
- Sits in front of the memory array as the only agent that drives its address, write-enable and write-data lines.

Parameters:
- AW, 8, address width. Depth is 2**AW.
- DW, 8, data width. The init pattern is the address truncated or zero-extended to DW.

Ports:
- clock  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_req  input  1  requester A access request; held until a_gnt.
- a_we  input  1  A: 1 = write, 0 = read.
- a_addr  input  AW  A address.
- a_wdata  input  DW  A write data.
- a_gnt  output  1  A granted this cycle (combinational).
- a_rvalid  output  1  A read data valid (registered).
- a_rdata  output  DW  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for requester B.
- init_done  output  1  memory fill complete; requests are accepted only when high.

Behaviour:
- Clock is clock; reset is rst_n, asynchronous, active-low.
- Reset values:
  - state = INIT, init_cnt = 0, last = B (so A wins the first tie).
  - init_done = 0; a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0.
  - a_gnt = b_gnt = 0.
- State INIT:
  - Each cycle writes mem[init_cnt] = init_cnt[DW-1:0], then init_cnt++.
  - After the write to address 2**AW-1, go to RUN and set init_done = 1 on the same edge.
  - Fill takes exactly 2**AW cycles (256 at default).
  - Gnt outputs are 0 and requests are ignored; requesters keep req high and wait.
- State RUN, grant (combinational from req, last and state):
  - Only one request: it is granted.
  - Both request: the one not equal to last is granted.
  - Neither: no grant.
- State RUN, on the edge where x_gnt = 1:
  - Memory is accessed at x_addr.
  - last updates to x.
  - A requester drops req, or presents its next request, in the cycle after seeing gnt.
  - Back-to-back requests from the same requester are granted every cycle when the other requester is idle.
- Reads:
  - x_rdata is registered and x_rvalid pulses for one cycle, exactly one cycle after the grant cycle.
  - x_rdata holds its value until the next read by x.
- Writes:
  - No rvalid.
  - A read of the same address in the following cycle returns the new data.
- Both requesters idle: memory is not enabled; rvalid = 0.
- Reset asserted mid-operation:
  - All state returns to reset values immediately.
  - A pending rvalid is dropped.
  - The fill restarts from address 0.
- RUN is terminal until reset; there is no return to INIT.
- Address wrap: init_cnt wraps to 0 after 2**AW-1, coincident with the transition to RUN. It is unused afterwards.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: A always wins a tie, the last register is removed, and B can starve.
- Undefined (default): round-robin as described above.
- The grant logic is the only difference.

Decomposition:
- Package mem_arb_pkg:
  - state enum {INIT, RUN}.
  - Requester index constants REQ_A = 0, REQ_B = 1.
  - Default AW/DW constants.
- Sub-module sp_ram (single-port synchronous RAM: clock, en, we, addr, wdata, registered rdata), instantiated once.
- The arbiter muxes the init sequencer and the granted requester onto sp_ram.
- rdata is steered to the requester recorded in a one-cycle rd_owner register.

Test Plan:
- Fill check:
  - Stimulus: release rst_n, a_req = 1 reading addr 0x00 from cycle 0.
  - Response: a_gnt = 0 and init_done = 0 for 256 cycles; then init_done = 1, a_gnt = 1; one cycle later a_rvalid = 1, a_rdata = 0x00.
  - Then read 0xFF → 0xFF.
- Single requester streaming:
  - Stimulus: B reads addresses 0x10..0x13 on consecutive cycles.
  - Response: b_gnt every cycle; b_rdata = 0x10, 0x11, 0x12, 0x13 on consecutive cycles, each one cycle after its grant.
- Tie round-robin:
  - Stimulus: A and B both request reads continuously, A at 0x20, B at 0x30.
  - Response: grants alternate A, B, A, B, starting with A after reset; rdata 0x20 and 0x30 on the matching rvalid.
  - With ARB_FIXED_PRIO_EN defined, A is granted every cycle.
- Write then read:
  - Stimulus: A writes 0x5A to 0x40; next cycle B reads 0x40.
  - Response: b_rvalid with b_rdata = 0x5A; no a_rvalid for the write.
- Reset mid-operation:
  - Stimulus: assert rst_n = 0 during a RUN read of 0x40 (after the 0x5A write).
  - Response: rvalid and init_done go to 0 immediately.
  - After release, 256 fill cycles follow, then a read of 0x40 returns 0x40 (the write is overwritten).
- Idle:
  - Stimulus: no requests for 10 cycles in RUN.
  - Response: no gnt, no rvalid; rdata unchanged.
